xy_route_switch: RTL and testbench
==================================

# xy_route_switch

Parametrised next-generation router core: accepts packets from `NUM_IN` input channels, computes a dimension-ordered XY route from the packet header, and switches each packet to one of three output ports (X, Y, LOCAL). It adds valid/ready flow control, per-port round-robin arbitration and registered outputs. It sits between the per-channel input FIFOs and the link drivers of one router node.

## Interface
- `NUM_IN`, default 3: number of input channels, minimum 2 (index 0 = X link, 1 = Y link, 2 = local by convention).
- `DATA_W`, default 40: packet width in bits.
- `COORD_W`, default 1: width of each X/Y coordinate. An address is `{y, x}`, 2*COORD_W bits.
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `cur_addr` in 2*COORD_W: this node's `{y, x}` address, quasi-static.
- `in_valid` in NUM_IN: per-input packet valid.
- `in_ready` out NUM_IN: per-input accept, combinational.
- `in_data` in NUM_IN*DATA_W: packed packets, input i at `[i*DATA_W +: DATA_W]`.
- `out_valid` out 3: per output port valid (0 = X, 1 = Y, 2 = LOCAL), registered.
- `out_ready` in 3: downstream accept per port.
- `out_data` out 3*DATA_W: packed registered packets.
- `out_src` out 3*$clog2(NUM_IN): index of the input that supplied each held packet.
- `dir` out 2*NUM_IN: registered route code per input.

## Operation
- Header fields: source address at `[DATA_W-1 -: 2*COORD_W]`; destination address at `[DATA_W-2*COORD_W-1 -: 2*COORD_W]`. Payload is never inspected.
- Route, computed combinationally per input:
  - If dst.x differs from cur.x: X port, code 01.
  - Else if dst.y differs from cur.y: Y port, code 10.
  - Else: LOCAL, code 11.
  - Code 00 means no request.
- `dir[i]` is registered every cycle: the route code when `in_valid[i]`, otherwise 00.
- A port slot is free when `!out_valid[p] || out_ready[p]`.
- Each port has one round-robin arbiter over the inputs routed to it. The search starts at `last_grant+1` mod NUM_IN.
  - The pointer updates only on a grant.
  - Reset pointer is NUM_IN-1, so input 0 has first priority.
- `in_ready[i]` = 1 iff input i is valid, routed to port p, port p's slot is free, and input i wins p's arbiter. An input requests exactly one port.
- On grant: `out_data[p]` is loaded with the packet, `out_src[p]` with i, and `out_valid[p]` is set.
- On `out_valid[p] && out_ready[p]` with no new grant: `out_valid[p]` clears. `out_data`/`out_src` keep their last value.
- Drain and load in the same cycle: the new packet replaces the old one, with no bubble.
- Packets are never dropped or duplicated. Order per input→port pair is preserved.

## Timing
- Latency from `in_valid&&in_ready` to `out_valid`: 1 cycle.
- Throughput: 1 packet per port per cycle; up to 3 packets per cycle total.
- `in_ready` depends combinationally on `in_valid`, `in_data`, `out_valid`, `out_ready` and the arbiter pointers. It has no dependency on its own registered outputs.
- While `out_valid[p]=1 && out_ready[p]=0`: `out_data[p]` and `out_src[p]` are stable, and every input routed to p sees `in_ready=0`.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0, `dir` = 0.
  - Arbiter pointers = NUM_IN-1.
  - `in_ready` = 0 during `rst`.
- Reset mid-operation: held packets are discarded, and the cycle after `rst` deasserts behaves as post-reset.
- A `cur_addr` change takes effect on routing the same cycle. Packets already held in output registers are unaffected.

## Structure
- Shared package `router_pkg`:
  - Direction codes `DIR_NONE=2'b00`, `DIR_X=2'b01`, `DIR_Y=2'b10`, `DIR_LOCAL=2'b11`.
  - Port indices `PORT_X=0`, `PORT_Y=1`, `PORT_LOCAL=2`, `NUM_OUT=3`.
  - A function `xy_route(cur, dst)` returning the code.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]`, `en` (slot free).
  - Outputs: one-hot `gnt[N]`.
  - Owns the pointer register and the synchronous reset.
  - Instantiated once per output port.

## Test plan
(Defaults, `cur_addr=2'b00`.)
- **Reset:** hold `rst`=1 for 2 cycles with all inputs valid → `out_valid=3'b000`, `dir=0`, `in_ready=0`. After release, input 0 wins first.
- **Single routes:** `in_data[2]=40'h10_0000_00AA` (dst 01) valid 1 cycle → `in_ready[2]=1`. Next cycle: `out_valid[0]=1`, `out_data[0]=40'h10_0000_00AA`, `out_src[0]=2`, `dir[2]=01`.
  - Repeat with 40'h20_… → Y port, `dir=10`.
  - Repeat with 40'h00_… → LOCAL, `dir=11`.
- **Contention:** inputs 0, 1, 2 all send dst 01 continuously, `out_ready[0]=1` → `out_src[0]` sequence 0,1,2,0,1,2. One accept per cycle, no gaps.
- **Backpressure:** `out_ready[0]=0` for 3 cycles with `out_valid[0]=1` → `out_data[0]` is stable and `in_ready` to X-routed inputs is 0. On release, the held packet drains and the next loads in the same cycle.
- **Parallel ports:** input 0 → X, input 1 → Y, input 2 → LOCAL in the same cycle → all three `in_ready=1`, and the next cycle has `out_valid=3'b111`.
- **Mid-reset:** assert `rst` while `out_valid[1]=1, out_ready[1]=0` → next cycle `out_valid[1]=0`. The packet is not delivered after reset.

Source files
------------

// File: rtl/router_pkg.sv
// Router shared definitions: direction codes, port indices
// and the dimension-ordered (X first, then Y) route function.
package router_pkg;

   typedef enum logic [1:0] {
      DIR_NONE  = 2'b00,
      DIR_X     = 2'b01,
      DIR_Y     = 2'b10,
      DIR_LOCAL = 2'b11
   } dir_e;

   localparam int PORT_X     = 0;
   localparam int PORT_Y     = 1;
   localparam int PORT_LOCAL = 2;
   localparam int NUM_OUT    = 3;

   // Addresses arrive zero-extended as {y, x}; cw is one coordinate's width.
   function automatic dir_e xy_route(
      input logic [31:0] cur,
      input logic [31:0] dst,
      input int          cw = 1
   );
      logic [31:0] mask;
      logic [31:0] diff;
      mask = (32'd1 << cw) - 32'd1;
      diff = cur ^ dst;
      if ((diff & mask) != '0)
         return DIR_X;
      if (((diff >> cw) & mask) != '0)
         return DIR_Y;
      return DIR_LOCAL;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant,
// pointer advances only when a grant is issued.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] j;
   logic          hit;

   always_comb begin
      gnt = '0;
      win = ptr;
      hit = 1'b0;
      j   = '0;
      for (int k = 1; k <= N; k++) begin
         j = PW'((int'(ptr) + k) % N);
         if (en && !hit && req[j]) begin
            gnt[j] = 1'b1;
            win    = j;
            hit    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= PW'(N - 1);
      else if (hit)
         ptr <= win;
   end

endmodule

// File: rtl/xy_route_switch.sv
// XY router switch core: per-input route, per-port round-robin
// arbitration and registered output slots with valid/ready.
module xy_route_switch
   import router_pkg::*;
#(
   parameter  int NUM_IN  = 3,
   parameter  int DATA_W  = 40,
   parameter  int COORD_W = 1,
   localparam int SW      = $clog2(NUM_IN)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2*COORD_W-1:0]      cur_addr,
   input  logic [NUM_IN-1:0]         in_valid,
   output logic [NUM_IN-1:0]         in_ready,
   input  logic [NUM_IN*DATA_W-1:0]  in_data,
   output logic [NUM_OUT-1:0]        out_valid,
   input  logic [NUM_OUT-1:0]        out_ready,
   output logic [NUM_OUT*DATA_W-1:0] out_data,
   output logic [NUM_OUT*SW-1:0]     out_src,
   output logic [2*NUM_IN-1:0]       dir
);

   localparam int AW = 2 * COORD_W;
   localparam int DH = DATA_W - AW - 1;

   logic [1:0]        route    [NUM_IN];
   logic [NUM_IN-1:0] req      [NUM_OUT];
   logic [NUM_IN-1:0] gnt      [NUM_OUT];
   logic [DATA_W-1:0] sel_data [NUM_OUT];
   logic [SW-1:0]     sel_src  [NUM_OUT];
   logic [NUM_OUT-1:0] load;
   logic [NUM_OUT-1:0] free;

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         route[i] = DIR_NONE;
         if (in_valid[i])
            route[i] = xy_route(
               32'(cur_addr),
               32'(in_data[i*DATA_W + DH -: AW]),
               COORD_W);
      end
   end

   // Route code k selects port k-1; DIR_NONE requests nothing.
   always_comb begin
      for (int p = 0; p < NUM_OUT; p++) begin
         req[p] = '0;
         for (int i = 0; i < NUM_IN; i++)
            req[p][i] = (route[i] == 2'(p + 1));
      end
   end

   assign free = ~out_valid | out_ready;

   for (genvar p = 0; p < NUM_OUT; p++) begin : g_arb
      rr_arbiter #(
         .N(NUM_IN)
      ) u_arb (
         .clk(clk),
         .rst(rst),
         .req(req[p]),
         .en(free[p] & ~rst),
         .gnt(gnt[p])
      );
   end

   always_comb begin
      in_ready = '0;
      for (int p = 0; p < NUM_OUT; p++) begin
         sel_data[p] = '0;
         sel_src[p]  = '0;
         load[p]     = |gnt[p];
         for (int i = 0; i < NUM_IN; i++) begin
            if (gnt[p][i]) begin
               sel_data[p] = in_data[i*DATA_W +: DATA_W];
               sel_src[p]  = SW'(i);
               in_ready[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= '0;
         out_data  <= '0;
         out_src   <= '0;
         dir       <= '0;
      end else begin
         for (int p = 0; p < NUM_OUT; p++) begin
            if (load[p]) begin
               out_valid[p]               <= 1'b1;
               out_data[p*DATA_W +: DATA_W] <= sel_data[p];
               out_src[p*SW +: SW]        <= sel_src[p];
            end else if (out_ready[p]) begin
               out_valid[p] <= 1'b0;
            end
         end
         for (int i = 0; i < NUM_IN; i++)
            dir[2*i +: 2] <= route[i];
      end
   end

endmodule

// File: tb/tb_xy_route_switch.sv
// Scoreboard bench for xy_route_switch: directed scenarios then
// random traffic against a behavioural routing/arbitration model.
module tb_xy_route_switch;

   localparam int N  = 3;
   localparam int DW = 40;
   localparam int CW = 1;
   localparam int SW = $clog2(N);

   logic            clk = 1'b0;
   logic            rst;
   logic [2*CW-1:0] cur_addr;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [N*DW-1:0] in_data;
   logic [2:0]      out_valid;
   logic [2:0]      out_ready;
   logic [3*DW-1:0] out_data;
   logic [3*SW-1:0] out_src;
   logic [2*N-1:0]  dir;

   always #5 clk = ~clk;

   xy_route_switch #(
      .NUM_IN(N),
      .DATA_W(DW),
      .COORD_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cur_addr(cur_addr),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_src(out_src),
      .dir(dir)
   );

   typedef struct {
      logic [DW-1:0] d;
      int            src;
   } exp_t;

   exp_t sbq [3][$];
   int checks = 0;
   int passed = 0;

   logic [DW-1:0]  pkt [N];
   bit             mvalid [3];
   int             last [3];
   logic [2*N-1:0] exp_dir;
   bit             known = 1'b0;

   task automatic check(input string nm,
                        input logic [63:0] got,
                        input logic [63:0] want);
      checks++;
      if (got === want)
         passed++;
      else
         $display("FAIL %s: got %0h want %0h", nm, got, want);
   endtask

   // 0 = X, 1 = Y, 2 = LOCAL, from coordinate arithmetic.
   function automatic int port_of(input logic [2*CW-1:0] cur,
                                  input logic [DW-1:0] p);
      int m, dst, c;
      m   = 1 << CW;
      dst = int'(p[DW-2*CW-1 -: 2*CW]);
      c   = int'(cur);
      if (dst % m != c % m) return 0;
      if (dst / m != c / m) return 1;
      return 2;
   endfunction

   task automatic step(input logic r,
                       input logic [N-1:0] v,
                       input logic [2:0] ord);
      logic [N-1:0] er;
      int above, low, win;
      rst = r;
      in_valid = v;
      out_ready = ord;
      for (int i = 0; i < N; i++)
         in_data[i*DW +: DW] = pkt[i];
      #1;
      er = '0;
      if (known) begin
         check("out_valid", 64'(out_valid),
               64'({mvalid[2], mvalid[1], mvalid[0]}));
         check("dir", 64'(dir), 64'(exp_dir));
      end
      if (r) begin
         check("in_ready_rst", 64'(in_ready), 64'(0));
         for (int p = 0; p < 3; p++) begin
            mvalid[p] = 1'b0;
            last[p] = N - 1;
            sbq[p].delete();
         end
         exp_dir = '0;
         known = 1'b1;
      end else begin
         for (int p = 0; p < 3; p++) begin
            win = -1;
            if (!mvalid[p] || ord[p]) begin
               above = -1;
               low = -1;
               for (int i = N - 1; i >= 0; i--)
                  if (v[i] && port_of(cur_addr, pkt[i]) == p) begin
                     low = i;
                     if (i > last[p]) above = i;
                  end
               win = (above >= 0) ? above : low;
            end
            if (win >= 0) begin
               er[win] = 1'b1;
               sbq[p].push_back('{pkt[win], win});
               last[p] = win;
               mvalid[p] = 1'b1;
            end else if (ord[p]) begin
               mvalid[p] = 1'b0;
            end
         end
         check("in_ready", 64'(in_ready), 64'(er));
         for (int i = 0; i < N; i++)
            exp_dir[2*i +: 2] = v[i] ?
               2'(port_of(cur_addr, pkt[i]) + 1) : 2'b00;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: checks every drained packet and held-slot stability.
   initial begin
      bit            held [3];
      logic [DW-1:0] hd [3];
      logic [SW-1:0] hs [3];
      exp_t          e;
      for (int p = 0; p < 3; p++) held[p] = 1'b0;
      forever begin
         @(negedge clk);
         for (int p = 0; p < 3; p++) begin
            if (rst) begin
               held[p] = 1'b0;
            end else begin
               if (held[p]) begin
                  check("hold_valid", 64'(out_valid[p]), 64'(1));
                  check("hold_data", 64'(out_data[p*DW +: DW]),
                        64'(hd[p]));
                  check("hold_src", 64'(out_src[p*SW +: SW]),
                        64'(hs[p]));
               end
               if (out_valid[p] && out_ready[p]) begin
                  if (sbq[p].size() == 0) begin
                     checks++;
                     $display("FAIL drain_extra port %0d: got %0h want none",
                              p, out_data[p*DW +: DW]);
                  end else begin
                     e = sbq[p].pop_front();
                     check("drain_data", 64'(out_data[p*DW +: DW]),
                           64'(e.d));
                     check("drain_src", 64'(out_src[p*SW +: SW]),
                           64'(e.src));
                  end
               end
               held[p] = out_valid[p] && !out_ready[p];
               hd[p] = out_data[p*DW +: DW];
               hs[p] = out_src[p*SW +: SW];
            end
         end
      end
   end

   function automatic logic [DW-1:0] rnd_pkt(input logic [7:0] hdr);
      return {hdr, 32'($urandom)};
   endfunction

   initial begin
      logic [2:0] ord;
      rst = 1'b1;
      cur_addr = '0;
      in_valid = '0;
      in_data = '0;
      out_ready = '0;
      for (int p = 0; p < 3; p++) begin
         mvalid[p] = 1'b0;
         last[p] = N - 1;
      end
      exp_dir = '0;
      @(posedge clk);
      #1;

      // Reset held two cycles with all inputs valid.
      for (int i = 0; i < N; i++) pkt[i] = rnd_pkt(8'h10);
      step(1'b1, 3'b111, 3'b111);
      step(1'b1, 3'b111, 3'b111);

      // Contention on X; input 0 first, then rotation.
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++) pkt[i] = rnd_pkt(8'h10);
         step(1'b0, 3'b111, 3'b111);
      end

      // Backpressure on X for three cycles, then release.
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < N; i++) pkt[i] = rnd_pkt(8'h10);
         step(1'b0, 3'b111, 3'b110);
      end
      step(1'b0, 3'b111, 3'b111);
      step(1'b0, 3'b000, 3'b111);

      // Single routes from input 2.
      pkt[0] = '0;
      pkt[1] = '0;
      pkt[2] = 40'h10_0000_00AA;
      step(1'b0, 3'b100, 3'b111);
      pkt[2] = 40'h20_0000_00BB;
      step(1'b0, 3'b100, 3'b111);
      pkt[2] = 40'h00_0000_00CC;
      step(1'b0, 3'b100, 3'b111);
      step(1'b0, 3'b000, 3'b111);

      // Parallel: one packet to each port in one cycle.
      pkt[0] = 40'h10_0000_0001;
      pkt[1] = 40'h20_0000_0002;
      pkt[2] = 40'h00_0000_0003;
      step(1'b0, 3'b111, 3'b111);
      step(1'b0, 3'b000, 3'b111);

      // Reset while Y holds a blocked packet.
      pkt[1] = 40'h20_0000_0D0D;
      step(1'b0, 3'b010, 3'b000);
      step(1'b0, 3'b000, 3'b000);
      step(1'b1, 3'b000, 3'b000);
      for (int c = 0; c < 3; c++) step(1'b0, 3'b000, 3'b111);

      // Random traffic.
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 49) == 0) cur_addr = 2'($urandom);
         for (int i = 0; i < N; i++) pkt[i] = DW'({$urandom, $urandom});
         for (int p = 0; p < 3; p++) ord[p] = ($urandom_range(0, 9) < 7);
         step($urandom_range(0, 199) == 0, N'($urandom), ord);
      end

      for (int c = 0; c < 4; c++) step(1'b0, 3'b000, 3'b111);
      for (int p = 0; p < 3; p++)
         check("queue_empty", 64'(sbq[p].size()), 64'(0));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
